// File: rtl/crypto_issue_sched.sv
// Single-issue scheduler for the crypto extension units: it latches one instruction, dispatches
// it to the ROR, ASCON or ChaCha unit, and returns a single result with a watchdog on slow units.
module crypto_issue_sched #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned IdWidth       = 4,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,

  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [3:0]         issue_opcode_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [4:0]         issue_rd_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  input  logic [XLEN-1:0]    issue_rs3_i,

  output logic [XLEN-1:0]    op_a_o,
  output logic [XLEN-1:0]    op_b_o,
  output logic [XLEN-1:0]    op_c_o,
  output logic               ror_hi_o,
  input  logic [XLEN-1:0]    ror_result_i,

  output logic               asc_start_o,
  input  logic               asc_done_i,
  input  logic [XLEN-1:0]    asc_result_i,
  output logic               cha_start_o,
  input  logic               cha_done_i,
  input  logic [XLEN-1:0]    cha_result_i,
  output logic               abort_o,

  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [4:0]         result_rd_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic               result_we_o,
  output logic               result_err_o,

  input  logic               flush_i,
  output logic               busy_o
);

  localparam int unsigned WdWidth = $clog2(TimeoutCycles + 1);
  localparam logic [WdWidth-1:0] WdLast = WdWidth'(TimeoutCycles - 1);

  localparam logic [3:0] OpNop    = 4'd1;
  localparam logic [3:0] OpRorH   = 4'd2;
  localparam logic [3:0] OpRorL   = 4'd3;
  localparam logic [3:0] OpAscon  = 4'd4;
  localparam logic [3:0] OpChacha = 4'd5;

  typedef enum logic [1:0] {StIdle, StFast, StSlow, StResp} state_e;

  state_e             state;
  logic [WdWidth-1:0] wdog;
  logic               sel_cha;
  logic               handshake;
  logic               sel_done;
  logic [XLEN-1:0]    sel_result;

  // Issue is also held off while reset is asserted so nothing is accepted into a resetting core.
  assign issue_ready_o = (state == StIdle) && !flush_i && !rst_i;
  assign handshake     = issue_valid_i && issue_ready_o;
  assign busy_o        = (state != StIdle);
  assign sel_done      = sel_cha ? cha_done_i : asc_done_i;
  assign sel_result    = sel_cha ? cha_result_i : asc_result_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= StIdle;
      wdog           <= '0;
      sel_cha        <= 1'b0;
      op_a_o         <= '0;
      op_b_o         <= '0;
      op_c_o         <= '0;
      ror_hi_o       <= 1'b0;
      asc_start_o    <= 1'b0;
      cha_start_o    <= 1'b0;
      abort_o        <= 1'b0;
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_rd_o    <= '0;
      result_data_o  <= '0;
      result_we_o    <= 1'b0;
      result_err_o   <= 1'b0;
    end else begin
      asc_start_o <= 1'b0;
      cha_start_o <= 1'b0;
      abort_o     <= 1'b0;
      unique case (state)
        StIdle: begin
          if (handshake) begin
            result_id_o   <= issue_id_i;
            result_rd_o   <= issue_rd_i;
            op_a_o        <= issue_rs1_i;
            op_b_o        <= issue_rs2_i;
            op_c_o        <= issue_rs3_i;
            ror_hi_o      <= (issue_opcode_i == OpRorH);
            sel_cha       <= (issue_opcode_i == OpChacha);
            wdog          <= '0;
            result_data_o <= '0;
            result_we_o   <= 1'b0;
            result_err_o  <= 1'b0;
            case (issue_opcode_i)
              OpNop: begin
                state          <= StResp;
                result_valid_o <= 1'b1;
              end
              OpRorH, OpRorL: state <= StFast;
              OpAscon: begin
                state       <= StSlow;
                asc_start_o <= 1'b1;
              end
              OpChacha: begin
                state       <= StSlow;
                cha_start_o <= 1'b1;
              end
              default: begin
                state          <= StResp;
                result_valid_o <= 1'b1;
                result_err_o   <= 1'b1;
              end
            endcase
          end
        end
        StFast: begin
          if (flush_i) begin
            abort_o <= 1'b1;
            state   <= StIdle;
          end else begin
            result_data_o  <= ror_result_i;
            result_we_o    <= 1'b1;
            result_valid_o <= 1'b1;
            state          <= StResp;
          end
        end
        StSlow: begin
          // Priority: flush, then unit completion, then watchdog expiry.
          if (flush_i) begin
            abort_o <= 1'b1;
            state   <= StIdle;
          end else if (sel_done) begin
            result_data_o  <= sel_result;
            result_we_o    <= 1'b1;
            result_valid_o <= 1'b1;
            state          <= StResp;
          end else if (wdog == WdLast) begin
            result_err_o   <= 1'b1;
            result_valid_o <= 1'b1;
            abort_o        <= 1'b1;
            state          <= StResp;
          end else begin
            wdog <= wdog + WdWidth'(1);
          end
        end
        StResp: begin
          if (flush_i || result_ready_i) begin
            result_valid_o <= 1'b0;
            state          <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
